// File: rtl/vec_column_sequencer_if.sv
// Pipeline-side view of the EX/MEM column sequencer: hazard inputs, stall/bubble
// controls and the column-write pair carried by the EX/MEM register.
interface vec_column_sequencer_if #(
  parameter int unsigned COL_W = 2,
  parameter int unsigned RD_W  = 5
);
  logic             flush;
  logic             ex_vreg_write;
  logic [1:0]       ex_mem_to_reg;
  logic             ex_reg_write;
  logic [RD_W-1:0]  ex_rd;
  logic [RD_W-1:0]  id_rs1;
  logic [RD_W-1:0]  id_rs2;
  logic             stall;
  logic             bubble;
  logic             col_write;
  logic [COL_W-1:0] columna;
  logic             col_last;
  logic             busy;

  // Pipeline side: presents EX/ID state, consumes stall/bubble and column controls.
  modport master (
    output flush, ex_vreg_write, ex_mem_to_reg, ex_reg_write, ex_rd, id_rs1, id_rs2,
    input  stall, bubble, col_write, columna, col_last, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, ex_vreg_write, ex_mem_to_reg, ex_reg_write, ex_rd, id_rs1, id_rs2,
    output stall, bubble, col_write, columna, col_last, busy
  );
endinterface

// File: rtl/vec_column_sequencer.sv
// EX/MEM controller for the SIMD AES core: splits a vector-register write into
// NUM_COLS column writes, freezes upstream stages meanwhile, and flags load-use hazards.
module vec_column_sequencer #(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned COL_W    = 2,
  parameter int unsigned RD_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  vec_column_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [1:0]       MEM_LOAD = 2'b01;

  state_t           state;
  logic [COL_W-1:0] cnt;
  logic [COL_W-1:0] cnt_inc;
  logic             col_write;
  logic [COL_W-1:0] columna;
  logic             col_last;
  logic             busy;

  logic start;
  logic hz;
  logic at_last;
  logic stall;
  logic bubble;

  assign cnt_inc = cnt + COL_W'(1);
  assign at_last = (cnt == LAST_COL);
  assign start   = bus.ex_vreg_write & (state == IDLE) & ~bus.flush;

  // Scalar load in EX whose destination is read by the instruction in ID.
  assign hz = bus.ex_reg_write
            & (bus.ex_mem_to_reg == MEM_LOAD)
            & (bus.ex_rd != RD_W'(0))
            & ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

  // Sweep FSM; column outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      col_write <= 1'b0;
      columna   <= '0;
      col_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      cnt       <= '0;
      col_write <= 1'b0;
      columna   <= '0;
      col_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SWEEP;
            cnt       <= '0;
            col_write <= 1'b1;
            columna   <= '0;
            col_last  <= (LAST_COL == '0);
            busy      <= 1'b1;
          end else begin
            state     <= IDLE;
            cnt       <= '0;
            col_write <= 1'b0;
            columna   <= '0;
            col_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        SWEEP: begin
          if (at_last) begin
            state     <= IDLE;
            cnt       <= '0;
            col_write <= 1'b0;
            columna   <= '0;
            col_last  <= 1'b0;
            busy      <= 1'b0;
          end else begin
            state     <= SWEEP;
            cnt       <= cnt_inc;
            col_write <= 1'b1;
            columna   <= cnt_inc;
            col_last  <= (cnt_inc == LAST_COL);
            busy      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          col_write <= 1'b0;
          columna   <= '0;
          col_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The final column releases the pipeline so it advances with the last write.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (!rst && !bus.flush) begin
      if (start) begin
        stall = 1'b1;
      end else if (state == SWEEP) begin
        stall = ~at_last;
      end else if (hz) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt <= LAST_COL);
    end
  end

  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.col_write = col_write;
  assign bus.columna   = columna;
  assign bus.col_last  = col_last;
  assign bus.busy      = busy;

endmodule
